// File: rtl/add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_stage
// Description : AES AddRoundKey pipeline stage. Joins a state block and a
//               round key over two independent valid/ready channels, registers
//               their XOR and presents it with a round index that wraps at NR.
//               Optional macro ARK_PARITY_EN adds out_parity[15:0], which holds
//               the even parity of each out_s byte.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state_in,
  input  logic         state_valid,
  output logic         state_ready,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         restart,
  output logic [127:0] out_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   round,
`ifdef ARK_PARITY_EN
  output logic [15:0]  out_parity,
`endif
  output logic         last_round
);

  localparam logic [3:0] c_round_max = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_S = 2'd1,
    HAVE_K = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_state_hold;
  logic [127:0] r_key_hold;
  logic [127:0] r_out_s;
  logic [3:0]   r_round;
  logic [127:0] w_op_s;
  logic [127:0] w_op_k;
  logic [127:0] w_xor;
  logic         w_s_xfer;
  logic         w_k_xfer;
  logic         w_out_xfer;
  logic         w_load;

  assign state_ready = (r_state == IDLE) || (r_state == HAVE_K);
  assign key_ready   = (r_state == IDLE) || (r_state == HAVE_S);
  assign w_s_xfer    = state_valid && state_ready;
  assign w_k_xfer    = key_valid && key_ready;
  assign out_valid   = (r_state == FULL);
  assign w_out_xfer  = out_valid && out_ready;

  // A held operand is used only in the state that holds it; otherwise the
  // live input is the operand completing the pair this cycle.
  assign w_op_s = (r_state == HAVE_S) ? r_state_hold : state_in;
  assign w_op_k = (r_state == HAVE_K) ? r_key_hold   : key_in;
  assign w_xor  = w_op_s ^ w_op_k;

  assign out_s      = r_out_s;
  assign round      = r_round;
  assign last_round = out_valid && (r_round == c_round_max);

  // Next-state decode; restart overrides every transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (restart) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s_xfer && w_k_xfer) begin
            w_state_nxt = FULL;
            w_load      = 1'b1;
          end else if (w_s_xfer) begin
            w_state_nxt = HAVE_S;
          end else if (w_k_xfer) begin
            w_state_nxt = HAVE_K;
          end
        end
        HAVE_S: begin
          if (w_k_xfer) begin
            w_state_nxt = FULL;
            w_load      = 1'b1;
          end
        end
        HAVE_K: begin
          if (w_s_xfer) begin
            w_state_nxt = FULL;
            w_load      = 1'b1;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture whichever operand arrives first; restart discards both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_hold <= '0;
      r_key_hold   <= '0;
    end else if (restart) begin
      r_state_hold <= '0;
      r_key_hold   <= '0;
    end else begin
      if (w_s_xfer) begin
        r_state_hold <= state_in;
      end
      if (w_k_xfer) begin
        r_key_hold <= key_in;
      end
    end
  end

  // Result register: loads only on entry to FULL, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_s <= '0;
    end else if (w_load) begin
      r_out_s <= w_xor;
    end
  end

  // Round index advances on each output handshake and wraps after NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= 4'd0;
    end else if (restart) begin
      r_round <= 4'd0;
    end else if (w_out_xfer) begin
      r_round <= (r_round == c_round_max) ? 4'd0 : r_round + 4'd1;
    end
  end

`ifdef ARK_PARITY_EN
  logic [15:0] w_parity;
  logic [15:0] r_parity;

  // Even parity of each result byte, computed from the value being loaded.
  always_comb begin
    w_parity = '0;
    for (int i = 0; i < 16; i++) begin
      w_parity[i] = ^w_xor[8*i +: 8];
    end
  end

  // Parity register tracks out_s exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= '0;
    end else if (w_load) begin
      r_parity <= w_parity;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_round_key_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_round_key_stage
// Description : Self-checking bench for add_round_key_stage. Stimulus pushes
//               expected results into a scoreboard queue; a monitor pops and
//               compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_round_key_stage;

  localparam int NR_TB = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] state_in = '0;
  logic         state_valid = 1'b0;
  logic         state_ready;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         restart = 1'b0;
  logic [127:0] out_s;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   round;
  logic         last_round;
`ifdef ARK_PARITY_EN
  logic [15:0]  out_parity;
`endif

  add_round_key_stage #(.NR(NR_TB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_in    (state_in),
    .state_valid (state_valid),
    .state_ready (state_ready),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .restart     (restart),
    .out_s       (out_s),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .round       (round),
`ifdef ARK_PARITY_EN
    .out_parity  (out_parity),
`endif
    .last_round  (last_round)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] s;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_round = 4'd0;

  localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_X = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] s);
    exp_t e;
    e.s = s;
    e.r = exp_round;
    e.l = (exp_round == 4'(NR_TB));
    sb.push_back(e);
    exp_round = (exp_round == 4'(NR_TB)) ? 4'd0 : exp_round + 4'd1;
  endtask

  // Bounded wait for IDLE (both readys high), sampled 1 time unit after an edge.
  task automatic wait_idle();
    int n = 0;
    while (!(state_ready && key_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle_timeout", 128'(n >= 20), 128'd0);
  endtask

  task automatic send_both(input logic [127:0] s, input logic [127:0] k);
    wait_idle();
    state_in = s; key_in = k;
    state_valid = 1'b1; key_valid = 1'b1;
    @(posedge clk); #1;
    state_valid = 1'b0; key_valid = 1'b0;
  endtask

`ifdef ARK_PARITY_EN
  function automatic logic [15:0] byte_par(input logic [127:0] v);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^v[8*i +: 8];
    return p;
  endfunction
`endif

  // Monitor: every output handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_s", out_s, e.s);
        chk("round", 128'(round), 128'(e.r));
        chk("last_round", 128'(last_round), 128'(e.l));
      end
    end
  end

  initial begin
    // Reset state while rst_n is low.
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_s", out_s, 128'd0);
    chk("rst_round", 128'(round), 128'd0);
    chk("rst_last_round", 128'(last_round), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_state_ready", 128'(state_ready), 128'd1);
    chk("post_rst_key_ready", 128'(key_ready), 128'd1);

    // FIPS-197 first AddRoundKey, both operands in the same cycle.
    out_ready = 1'b1;
    push_exp(FIPS_X);
    send_both(FIPS_S, FIPS_K);
    chk("fips_out_valid", 128'(out_valid), 128'd1);
    chk("fips_out_s", out_s, FIPS_X);

    // State first, key three cycles later; consumer stalls five cycles.
    wait_idle();
    out_ready = 1'b0;
    state_in = {16{8'hAA}}; state_valid = 1'b1;
    @(posedge clk); #1;
    state_valid = 1'b0; state_in = {16{8'h77}};
    chk("have_s_state_ready", 128'(state_ready), 128'd0);
    chk("have_s_key_ready", 128'(key_ready), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("have_s_hold_out_valid", 128'(out_valid), 128'd0);
    key_in = {16{8'h55}}; key_valid = 1'b1;
    push_exp({16{8'hFF}});
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("late_key_out_valid", 128'(out_valid), 128'd1);
    state_valid = 1'b1; key_valid = 1'b1;
    state_in = {16{8'h12}}; key_in = {16{8'h34}};
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_s", out_s, {16{8'hFF}});
      chk("stall_round", 128'(round), 128'd1);
      chk("stall_readys", 128'({state_ready, key_ready}), 128'd0);
      chk("stall_out_valid", 128'(out_valid), 128'd1);
      @(posedge clk); #1;
    end
    state_valid = 1'b0; key_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_hs_out_valid", 128'(out_valid), 128'd0);

    // Key first, state later.
    wait_idle();
    key_in = {16{8'h0F}}; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_in = '0;
    chk("have_k_readys", 128'({state_ready, key_ready}), 128'b10);
    state_in = {16{8'h3C}}; state_valid = 1'b1;
    push_exp({16{8'h33}});
    @(posedge clk); #1;
    state_valid = 1'b0;

    // Restart clears the round counter, then a full round-index sweep.
    wait_idle();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    exp_round = 4'd0;
    chk("restart_idle_round", 128'(round), 128'd0);
    for (int i = 0; i < 15; i++) begin
      push_exp({8'(i + 16), 112'h0, 8'(i + 1)});
      send_both({120'h0, 8'(i + 1)}, {8'(i + 16), 120'h0});
    end

    // Restart while HAVE_S with round 4 discards the held state.
    wait_idle();
    state_in = {16{8'h77}}; state_valid = 1'b1;
    @(posedge clk); #1;
    state_valid = 1'b0;
    chk("pre_restart_round", 128'(round), 128'd4);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    exp_round = 4'd0;
    chk("restart_round", 128'(round), 128'd0);
    chk("restart_readys", 128'({state_ready, key_ready}), 128'b11);
    chk("restart_out_valid", 128'(out_valid), 128'd0);
    key_in = {16{8'h22}}; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("discarded_state_out_valid", 128'(out_valid), 128'd0);
    state_in = {16{8'h11}}; state_valid = 1'b1;
    push_exp({16{8'h33}});
    @(posedge clk); #1;
    state_valid = 1'b0;

    // Asynchronous reset while FULL, between clock edges.
    wait_idle();
    out_ready = 1'b0;
    send_both(FIPS_S, FIPS_K);
    chk("pre_rst_out_valid", 128'(out_valid), 128'd1);
`ifdef ARK_PARITY_EN
    chk("out_parity", 128'(out_parity), 128'(byte_par(FIPS_X)));
`endif
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 128'(out_valid), 128'd0);
    chk("async_rst_out_s", out_s, 128'd0);
`ifdef ARK_PARITY_EN
    chk("async_rst_parity", 128'(out_parity), 128'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter: NR, 10, number of AES rounds (10/12/14); round counter wraps after round NR.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 state_in  input  128  state block from mixColumns (or shiftRows on the final round).
REQ-005 state_valid  input  1  state_in holds a valid block.
REQ-006 state_ready  output  1  stage accepts state_in this cycle.
REQ-007 key_in  input  128  round key for the current round.
REQ-008 key_valid  input  1  key_in holds a valid round key.
REQ-009 key_ready  output  1  stage accepts key_in this cycle.
REQ-010 restart  input  1  synchronous: clear round counter, discard held inputs and output.
REQ-011 out_s  output  128  registered state_in XOR key_in.
REQ-012 out_valid  output  1  out_s holds a valid result.
REQ-013 out_ready  input  1  consumer accepts out_s this cycle.
REQ-014 round  output  4  round index of the block currently in out_s (0..NR).
REQ-015 last_round  output  1  high with out_valid when round == NR.

Function
REQ-016 The FSM SHALL have four states: IDLE, HAVE_S (state held, key awaited), HAVE_K (key held, state awaited), FULL (result in out_s).
REQ-017 A transfer SHALL occur on a channel only when its valid and ready are both high at a rising clk edge.
REQ-018 state_ready SHALL be high in IDLE and HAVE_K; key_ready SHALL be high in IDLE and HAVE_S; both SHALL be low in FULL.
REQ-019 IDLE: state-only transfer -> HAVE_S; key-only transfer -> HAVE_K; both same cycle -> FULL; neither -> IDLE.
REQ-020 HAVE_S on key transfer, and HAVE_K on state transfer, SHALL go to FULL; otherwise remain.
REQ-021 On entering FULL, out_s SHALL load the bitwise XOR of the two 128-bit operands (held or live) and out_valid SHALL rise; latency 1 cycle after the completing transfer.
REQ-022 In FULL, out_s, round and last_round SHALL stay stable until out_valid && out_ready; then go to IDLE with out_valid low the next cycle (throughput: one block per 2 cycles minimum).
REQ-023 The round counter SHALL increment on each output handshake, wrapping from NR to 0.
REQ-024 restart SHALL take priority over all transfers: next state IDLE, round = 0, out_valid = 0, held operands discarded.
REQ-025 out_s SHALL be unchanged when not loading; no combinational path from state_in/key_in to out_s.

Reset
REQ-026 While rst_n is low: FSM = IDLE, out_s = 0, out_valid = 0, round = 0, last_round = 0, held operands = 0.
REQ-027 State_ready and key_ready SHALL read 1 one cycle after rst_n deasserts (IDLE decode).
REQ-028 Reset asserted mid-operation SHALL abort any held operand or pending output immediately, without waiting for a clock.

Configuration
REQ-029 Macro ARK_PARITY_EN: when defined, an extra output out_parity [15:0] SHALL carry even parity of each out_s byte (bit i = XOR of out_s[8i+7:8i]), registered with out_s, reset 0.
REQ-030 Without ARK_PARITY_EN the out_parity port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then state_in=0x3243f6a8885a308d313198a2e0370734 and key_in=0x2b7e151628aed2a6abf7158809cf4f3c valid same cycle -> next cycle out_valid=1, out_s=0x193de3bea0f4e22b9ac68d2ae9f84808, round=0.
REQ-032 State valid cycle N, key valid cycle N+3 -> state_ready low from N+1, out_valid high at N+4 with correct XOR.
REQ-033 out_ready held low 5 cycles in FULL -> out_s/round stable, both readys low, no input accepted.
REQ-034 Eleven blocks with NR=10 -> round 0..10, last_round high only on the 11th, 12th block shows round=0.
REQ-035 restart pulsed in HAVE_S with round=4 -> IDLE, round=0, held state discarded, out_valid 0.
REQ-036 rst_n pulled low while FULL between clock edges -> out_valid and out_s clear immediately; with ARK_PARITY_EN, out_parity for REQ-031 result = byte-wise parity of 0x193de3be..4808.
